// File: rtl/carfield_clkdiv_sequencer.sv
// rtl/carfield_clkdiv_sequencer.sv - per-domain clock divider init and glitch-safe runtime reprogramming
module carfield_clkdiv_sequencer #(
  parameter int unsigned NumDomains = 6,
  parameter int unsigned DivWidth = 8,
  parameter logic [NumDomains*DivWidth-1:0] DefaultDiv = {NumDomains{DivWidth'(1)}},
  parameter int unsigned GateSettleCycles = 4,
  localparam int unsigned DomW = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [DomW-1:0]                req_domain_i,
  input  logic [DivWidth-1:0]            req_div_i,
  output logic [NumDomains*DivWidth-1:0] div_value_o,
  output logic [NumDomains-1:0]          div_valid_o,
  input  logic [NumDomains-1:0]          div_ready_i,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic                           busy_o,
  output logic                           init_done_o,
  output logic                           err_o,
  input  logic                           err_clr_i
);

  localparam int unsigned CntW = $clog2(GateSettleCycles + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(GateSettleCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(1);
  localparam logic [DomW:0] NumDomL = (DomW + 1)'(NumDomains);
  localparam logic [DomW-1:0] LastDom = DomW'(NumDomains - 1);

  typedef enum logic [2:0] {INIT, IDLE, SETTLE, LOAD, RESUME} state_t;

  state_t                         state_q, state_n;
  logic [CntW-1:0]                cnt_q, cnt_n;
  logic [DomW-1:0]                dom_q;
  logic [NumDomains*DivWidth-1:0] div_value_q;
  logic [NumDomains-1:0]          clk_en_q;
  logic                           busy_q, init_done_q, err_q;
  logic                           accept, req_bad, resume_end;

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    req_bad    = ({1'b0, req_domain_i} >= NumDomL) || (req_div_i == '0);
    accept     = (state_q == IDLE) && req_valid_i;
    resume_end = (state_q == RESUME) && (cnt_q == CntLast);
    case (state_q)
      INIT: begin
        cnt_n   = CntInit;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CntLast) state_n = LOAD;
        else cnt_n = cnt_q - CntLast;
      end
      LOAD: begin
        if (div_ready_i[dom_q]) begin
          state_n = RESUME;
          cnt_n   = CntInit;
        end
      end
      RESUME: begin
        if (cnt_q == CntLast) state_n = (!init_done_q && dom_q != LastDom) ? INIT : IDLE;
        else cnt_n = cnt_q - CntLast;
      end
      IDLE: begin
        // Invalid requests are consumed here without leaving IDLE.
        if (accept && !req_bad) begin
          state_n = SETTLE;
          cnt_n   = CntInit;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      dom_q       <= '0;
      div_value_q <= DefaultDiv;
      clk_en_q    <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n != IDLE);
      if (state_q == INIT) clk_en_q[dom_q] <= 1'b0;
      if (resume_end) begin
        clk_en_q[dom_q] <= 1'b1;
        if (!init_done_q) begin
          if (dom_q == LastDom) init_done_q <= 1'b1;
          else dom_q <= dom_q + DomW'(1);
        end
      end
      if (accept && !req_bad) begin
        dom_q                                     <= req_domain_i;
        clk_en_q[req_domain_i]                    <= 1'b0;
        div_value_q[req_domain_i*DivWidth +: DivWidth] <= req_div_i;
      end
      if (accept && req_bad) err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  always_comb begin
    div_valid_o = '0;
    if (state_q == LOAD) div_valid_o[dom_q] = 1'b1;
  end

  assign req_ready_o = (state_q == IDLE);
  assign div_value_o = div_value_q;
  assign clk_en_o    = clk_en_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_carfield_clkdiv_sequencer.sv
// tb/tb_carfield_clkdiv_sequencer.sv - scoreboard bench for carfield_clkdiv_sequencer
module tb_carfield_clkdiv_sequencer;

  localparam int N = 6;
  localparam int W = 8;
  localparam int G = 4;
  localparam logic [N*W-1:0] DEF = 48'h01_01_01_01_01_01;

  typedef struct {
    int dom;
    int div;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready_o;
  logic [2:0]     req_domain = '0;
  logic [W-1:0]   req_div = '0;
  logic [N*W-1:0] div_value_o;
  logic [N-1:0]   div_valid_o;
  logic [N-1:0]   div_ready = '1;
  logic [N-1:0]   clk_en_o;
  logic           busy_o, init_done_o, err_o;
  logic           err_clr = 1'b0;

  int             errors = 0;
  int             checks = 0;
  exp_t           sb[$];
  exp_t           mon_e;
  logic [N*W-1:0] model;

  carfield_clkdiv_sequencer #(
    .NumDomains(N), .DivWidth(W), .DefaultDiv(DEF), .GateSettleCycles(G)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_domain_i(req_domain), .req_div_i(req_div),
    .div_value_o(div_value_o), .div_valid_o(div_valid_o), .div_ready_i(div_ready),
    .clk_en_o(clk_en_o), .busy_o(busy_o), .init_done_o(init_done_o),
    .err_o(err_o), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every completed load handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (div_valid_o & div_ready) != '0) begin
      check("valid_onehot", 64'($countones(div_valid_o)), 64'd1);
      for (int d = 0; d < N; d++) begin
        if (div_valid_o[d] && div_ready[d]) begin
          if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
          else begin
            mon_e = sb.pop_front();
            check("sb_dom", 64'(d), 64'(mon_e.dom));
            check("sb_div", 64'(div_value_o[d*W +: W]), 64'(mon_e.div));
          end
        end
      end
    end
  end

  task automatic wait_init();
    int n = 0;
    int pulses = 0;
    for (int d = 0; d < N; d++) sb.push_back('{d, 1});
    while (!init_done_o && n < 300) begin
      if (div_valid_o != '0) begin
        pulses++;
        check("init_order", 64'(clk_en_o), 64'(div_valid_o - 1'b1));
      end
      tick();
      n++;
    end
    check("init_done", 64'(init_done_o), 64'd1);
    check("init_pulses", 64'(pulses), 64'(N));
    check("init_clk_en", 64'(clk_en_o), 64'h3F);
    check("init_div", 64'(div_value_o), 64'(DEF));
    check("init_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic issue(input int dom, input int div);
    req_valid  = 1'b1;
    req_domain = 3'(dom);
    req_div    = W'(div);
    if (dom < N && div != 0) begin
      sb.push_back('{dom, div});
      model[dom*W +: W] = W'(div);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!req_ready_o && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    model = DEF;
    repeat (3) tick();
    check("rst_clk_en", 64'(clk_en_o), 64'h0);
    check("rst_div_valid", 64'(div_valid_o), 64'h0);
    check("rst_div_value", 64'(div_value_o), 64'(DEF));
    check("rst_flags", {req_ready_o, busy_o, init_done_o, err_o}, 64'h0);
    rst = 1'b0;
    wait_init();
    check("idle_ready", 64'(req_ready_o), 64'd1);
    check("idle_busy", 64'(busy_o), 64'd0);

    // domain 3 <- 8, exact timing relative to accept cycle t
    issue(3, 8);
    check("req_gate", 64'(clk_en_o), 64'h37);
    check("req_value", 64'(div_value_o), 64'(model));
    check("req_busy", {busy_o, req_ready_o}, 64'h2);
    repeat (3) tick();
    check("req_no_early_valid", 64'(div_valid_o), 64'h0);
    tick();
    check("req_valid_t5", 64'(div_valid_o), 64'h08);
    repeat (4) tick();
    check("req_still_gated", 64'(clk_en_o), 64'h37);
    tick();
    check("req_ungate", 64'(clk_en_o), 64'h3F);
    check("req_idle", {busy_o, req_ready_o}, 64'h1);
    check("req_sb_empty", 64'(sb.size()), 64'd0);

    // same value again, load acknowledge withheld for 10 cycles
    div_ready = 6'h37;
    issue(3, 8);
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", 64'(div_valid_o), 64'h08);
      check("stall_value", 64'(div_value_o), 64'(model));
      check("stall_flags", {busy_o, req_ready_o, clk_en_o}, {2'b10, 6'h37});
      tick();
    end
    div_ready = '1;
    wait_idle("stall_done");
    check("stall_clk_en", 64'(clk_en_o), 64'h3F);
    check("stall_sb_empty", 64'(sb.size()), 64'd0);

    // invalid requests and error clear priority
    issue(7, 5);
    check("bad_dom_err", 64'(err_o), 64'd1);
    check("bad_dom_outs", {req_ready_o, busy_o, div_valid_o, clk_en_o}, {2'b10, 6'h00, 6'h3F});
    check("bad_dom_value", 64'(div_value_o), 64'(model));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 64'(err_o), 64'd0);
    issue(2, 0);
    check("bad_div_err", 64'(err_o), 64'd1);
    check("bad_div_value", 64'(div_value_o), 64'(model));
    err_clr = 1'b1;
    issue(2, 0);
    err_clr = 1'b0;
    check("err_set_wins", 64'(err_o), 64'd1);
    check("err_still_idle", {req_ready_o, clk_en_o}, {1'b1, 6'h3F});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr2", 64'(err_o), 64'd0);

    // valid held high across a sequence: second accept waits for first to finish
    begin
      int n = 0;
      req_valid = 1'b1; req_domain = 3'd1; req_div = 8'd3;
      sb.push_back('{1, 3});
      model[1*W +: W] = 8'd3;
      tick();
      req_domain = 3'd4; req_div = 8'd5;
      sb.push_back('{4, 5});
      model[4*W +: W] = 8'd5;
      while (!req_ready_o && n < 100) begin
        tick();
        n++;
      end
      check("held_latency", 64'(n), 64'(2 * G + 1));
      check("held_first_done", 64'(clk_en_o), 64'h3F);
      tick();
      req_valid = 1'b0;
      check("held_second_gate", 64'(clk_en_o), 64'h2F);
      wait_idle("held_done");
      check("held_value", 64'(div_value_o), 64'(model));
      check("held_sb_empty", 64'(sb.size()), 64'd0);
    end

    // reset during LOAD
    div_ready = 6'h1F;
    issue(5, 9);
    begin
      int n = 0;
      while (div_valid_o != 6'h20 && n < 20) begin
        tick();
        n++;
      end
      check("rl_in_load", 64'(div_valid_o), 64'h20);
    end
    tick();
    rst = 1'b1;
    tick();
    check("rl_clk_en", 64'(clk_en_o), 64'h0);
    check("rl_div_valid", 64'(div_valid_o), 64'h0);
    check("rl_div_value", 64'(div_value_o), 64'(DEF));
    check("rl_flags", {req_ready_o, busy_o, init_done_o, err_o}, 64'h0);
    sb.delete();
    model = DEF;
    div_ready = '1;
    rst = 1'b0;
    wait_init();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
